// File: rtl/neosd_dat_ctrl.sv
// rtl/neosd_dat_ctrl.sv - SD DAT-line single-block transfer sequencer (optional busy timeout: NEOSD_DAT_BUSY_TOUT_EN)
module neosd_dat_ctrl #(
    parameter int WCNT_W = 7,
    parameter int TOUT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clkstrb_i,
    output logic              run_o,
    input  logic              start_i,
    input  logic              rnw_i,
    input  logic              d4_i,
    input  logic [WCNT_W-1:0] blk_words_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [2:0]        err_o,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic              dp_clr_o,
    output logic              ctrl_rnw_o,
    output logic              ctrl_d4_o,
    output logic              ctrl_rot_reg_o,
    output logic [1:0]        ctrl_omux_o,
    output logic              ctrl_output_crc_o,
    output logic              shift_s_o,
    output logic              load_p_o,
    output logic [3:0]        sd_dat_oe_o,
    input  logic              sd_dat0_i,
    input  logic              crc_nonzero_i
);

    typedef enum logic [3:0] {
        IDLE, W_FILL, W_START, W_DATA, W_NEXT, W_CRC, W_END, W_SWAIT,
        W_STAT, W_SEND, W_BUSY, R_WAIT, R_DATA, R_CRC, R_END, DONE
    } state_t;

    localparam logic [2:0] ERR_OK   = 3'd0;
    localparam logic [2:0] ERR_TOUT = 3'd1;
    localparam logic [2:0] ERR_CRC  = 3'd2;
    localparam logic [2:0] ERR_END  = 3'd3;
    localparam logic [2:0] ERR_REJ  = 3'd4;
`ifdef NEOSD_DAT_BUSY_TOUT_EN
    localparam logic [2:0] ERR_BUSY = 3'd5;
`endif

    localparam logic [1:0] OMUX_ZERO = 2'd0;
    localparam logic [1:0] OMUX_ONE  = 2'd1;
    localparam logic [1:0] OMUX_DATA = 2'd2;
    localparam logic [1:0] OMUX_CRC  = 2'd3;

    // Timeout fires on the strobe that would bring the counter to all-ones,
    // i.e. after 2^TOUT_W-1 strobes without the expected response.
    localparam logic [TOUT_W-1:0] TOUT_LAST = {{(TOUT_W-1){1'b1}}, 1'b0};
    localparam logic [TOUT_W-1:0] TOUT_ONE  = {{(TOUT_W-1){1'b0}}, 1'b1};
    localparam logic [WCNT_W-1:0] WORD_ONE  = {{(WCNT_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic                rnw_q, d4_q;
    logic [WCNT_W-1:0]   blk_q, word_cnt_q;
    logic [4:0]          bit_cnt_q;
    logic [3:0]          crc_cnt_q;
    logic [TOUT_W-1:0]   tout_cnt_q;
    logic [1:0]          stat_q;
    logic                rvalid_q;
    logic [2:0]          err_q;

    logic                start_acc, bit_inc, word_inc, crc_inc;
    logic                tout_clr, tout_inc, stat_shift, rvalid_set, err_set;
    logic [2:0]          err_code;

    logic                bit_last, word_last, crc_last, tout_hit;
    logic [3:0]          oe_on;
    logic [2:0]          stat_word;

    // Higher rank wins when several errors hit one transfer: 1 > 3 > 2 > 4 > 5.
    function automatic logic [2:0] err_rank(input logic [2:0] code);
        case (code)
            3'd1:    err_rank = 3'd5;
            3'd3:    err_rank = 3'd4;
            3'd2:    err_rank = 3'd3;
            3'd4:    err_rank = 3'd2;
            3'd5:    err_rank = 3'd1;
            default: err_rank = 3'd0;
        endcase
    endfunction

    assign bit_last  = (bit_cnt_q == (d4_q ? 5'd7 : 5'd31));
    assign word_last = (word_cnt_q == blk_q);
    assign crc_last  = (crc_cnt_q == 4'd15);
    assign tout_hit  = (tout_cnt_q == TOUT_LAST);
    assign oe_on     = d4_q ? 4'hF : 4'h1;
    assign stat_word = {stat_q, sd_dat0_i};

    assign busy_o     = (state_q != IDLE);
    assign err_o      = err_q;
    assign rvalid_o   = rvalid_q;
    assign ctrl_rnw_o = rnw_q;
    assign ctrl_d4_o  = d4_q;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath controls and counter/error actions per state
    always_comb begin
        state_d           = state_q;
        run_o             = !(rvalid_q && !rready_i);
        wready_o          = 1'b0;
        load_p_o          = 1'b0;
        dp_clr_o          = 1'b0;
        shift_s_o         = 1'b0;
        ctrl_rot_reg_o    = 1'b0;
        ctrl_omux_o       = OMUX_ONE;
        ctrl_output_crc_o = 1'b0;
        sd_dat_oe_o       = 4'h0;
        done_o            = 1'b0;
        start_acc         = 1'b0;
        bit_inc           = 1'b0;
        word_inc          = 1'b0;
        crc_inc           = 1'b0;
        tout_clr          = 1'b0;
        tout_inc          = 1'b0;
        stat_shift        = 1'b0;
        rvalid_set        = 1'b0;
        err_set           = 1'b0;
        err_code          = ERR_OK;

        case (state_q)
            IDLE: begin
                if (start_i && !rst_i) begin
                    start_acc = 1'b1;
                    dp_clr_o  = 1'b1;
                    state_d   = rnw_i ? R_WAIT : W_FILL;
                end
            end
            W_FILL: begin
                wready_o = 1'b1;
                run_o    = 1'b0;
                if (wvalid_i) begin
                    load_p_o = 1'b1;
                    state_d  = W_START;
                end
            end
            W_START: begin
                sd_dat_oe_o = oe_on;
                ctrl_omux_o = OMUX_ZERO;
                if (clkstrb_i) begin
                    state_d = W_DATA;
                end
            end
            W_DATA: begin
                sd_dat_oe_o    = oe_on;
                ctrl_omux_o    = OMUX_DATA;
                shift_s_o      = 1'b1;
                ctrl_rot_reg_o = !d4_q;
                if (clkstrb_i) begin
                    bit_inc = 1'b1;
                    if (bit_last) begin
                        if (word_last) begin
                            state_d = W_CRC;
                        end else begin
                            word_inc = 1'b1;
                            state_d  = W_NEXT;
                        end
                    end
                end
            end
            W_NEXT: begin
                sd_dat_oe_o    = oe_on;
                ctrl_omux_o    = OMUX_DATA;
                ctrl_rot_reg_o = !d4_q;
                wready_o       = 1'b1;
                run_o          = 1'b0;
                if (wvalid_i) begin
                    load_p_o = 1'b1;
                    state_d  = W_DATA;
                end
            end
            W_CRC: begin
                sd_dat_oe_o       = oe_on;
                ctrl_omux_o       = OMUX_CRC;
                ctrl_output_crc_o = 1'b1;
                shift_s_o         = 1'b1;
                if (clkstrb_i) begin
                    crc_inc = 1'b1;
                    if (crc_last) begin
                        state_d = W_END;
                    end
                end
            end
            W_END: begin
                sd_dat_oe_o = oe_on;
                ctrl_omux_o = OMUX_ONE;
                if (clkstrb_i) begin
                    tout_clr = 1'b1;
                    state_d  = W_SWAIT;
                end
            end
            W_SWAIT: begin
                if (clkstrb_i) begin
                    if (!sd_dat0_i) begin
                        state_d = W_STAT;
                    end else if (tout_hit) begin
                        err_set  = 1'b1;
                        err_code = ERR_TOUT;
                        state_d  = DONE;
                    end else begin
                        tout_inc = 1'b1;
                    end
                end
            end
            W_STAT: begin
                // bit_cnt_q is zero here: it wrapped on the final data bit.
                if (clkstrb_i) begin
                    stat_shift = 1'b1;
                    bit_inc    = 1'b1;
                    if (bit_cnt_q == 5'd2) begin
                        if (stat_word != 3'b010) begin
                            err_set  = 1'b1;
                            err_code = ERR_REJ;
                        end
                        state_d = W_SEND;
                    end
                end
            end
            W_SEND: begin
                if (clkstrb_i) begin
                    tout_clr = 1'b1;
                    state_d  = W_BUSY;
                end
            end
            W_BUSY: begin
                if (clkstrb_i) begin
                    if (sd_dat0_i) begin
                        state_d = DONE;
`ifdef NEOSD_DAT_BUSY_TOUT_EN
                    end else if (tout_hit) begin
                        err_set  = 1'b1;
                        err_code = ERR_BUSY;
                        state_d  = DONE;
                    end else begin
                        tout_inc = 1'b1;
`endif
                    end
                end
            end
            R_WAIT: begin
                if (clkstrb_i) begin
                    if (!sd_dat0_i) begin
                        state_d = R_DATA;
                    end else if (tout_hit) begin
                        err_set  = 1'b1;
                        err_code = ERR_TOUT;
                        state_d  = DONE;
                    end else begin
                        tout_inc = 1'b1;
                    end
                end
            end
            R_DATA: begin
                shift_s_o      = 1'b1;
                ctrl_rot_reg_o = !d4_q;
                if (clkstrb_i) begin
                    bit_inc = 1'b1;
                    if (bit_last) begin
                        rvalid_set = 1'b1;
                        if (word_last) begin
                            state_d = R_CRC;
                        end else begin
                            word_inc = 1'b1;
                        end
                    end
                end
            end
            R_CRC: begin
                shift_s_o = 1'b1;
                if (clkstrb_i) begin
                    crc_inc = 1'b1;
                    if (crc_last) begin
                        state_d = R_END;
                    end
                end
            end
            R_END: begin
                // A strobe here implies the last word is being (or was) accepted,
                // so rvalid is clear by the time DONE is reached.
                if (clkstrb_i) begin
                    if (!sd_dat0_i) begin
                        err_set  = 1'b1;
                        err_code = ERR_END;
                    end else if (crc_nonzero_i) begin
                        err_set  = 1'b1;
                        err_code = ERR_CRC;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latched transfer setup, counters, status shifter, read handshake and result code
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rnw_q      <= 1'b0;
            d4_q       <= 1'b0;
            blk_q      <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            crc_cnt_q  <= '0;
            tout_cnt_q <= '0;
            stat_q     <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= ERR_OK;
        end else begin
            if (start_acc) begin
                rnw_q      <= rnw_i;
                d4_q       <= d4_i;
                blk_q      <= blk_words_i;
                bit_cnt_q  <= '0;
                word_cnt_q <= '0;
                crc_cnt_q  <= '0;
                tout_cnt_q <= '0;
                err_q      <= ERR_OK;
            end else begin
                if (bit_inc) begin
                    bit_cnt_q <= bit_last ? 5'd0 : bit_cnt_q + 5'd1;
                end
                if (word_inc) begin
                    word_cnt_q <= word_cnt_q + WORD_ONE;
                end
                if (crc_inc) begin
                    crc_cnt_q <= crc_cnt_q + 4'd1;
                end
                if (tout_clr) begin
                    tout_cnt_q <= '0;
                end else if (tout_inc && (tout_cnt_q != '1)) begin
                    tout_cnt_q <= tout_cnt_q + TOUT_ONE;
                end
                if (err_set && (err_rank(err_code) > err_rank(err_q))) begin
                    err_q <= err_code;
                end
            end
            if (stat_shift) begin
                stat_q <= stat_word[1:0];
            end
            if (rvalid_set) begin
                rvalid_q <= 1'b1;
            end else if (rready_i) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neosd_dat_ctrl.sv
// tb/tb_neosd_dat_ctrl.sv - self-checking bench for neosd_dat_ctrl
module tb_neosd_dat_ctrl;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       clkstrb_i;
    logic       run_o;
    logic       start_i = 1'b0;
    logic       rnw_i = 1'b0;
    logic       d4_i = 1'b0;
    logic [6:0] blk_words_i = '0;
    logic       busy_o, done_o;
    logic [2:0] err_o;
    logic       wvalid_i = 1'b0;
    logic       wready_o, rvalid_o;
    logic       rready_i = 1'b1;
    logic       dp_clr_o, ctrl_rnw_o, ctrl_d4_o, ctrl_rot_reg_o;
    logic [1:0] ctrl_omux_o;
    logic       ctrl_output_crc_o, shift_s_o, load_p_o;
    logic [3:0] sd_dat_oe_o;
    logic       sd_dat0_i;
    logic       crc_nonzero_i = 1'b0;

    logic       strb_raw = 1'b0;

    neosd_dat_ctrl #(.WCNT_W(7), .TOUT_W(6)) dut (
        .clk_i(clk), .rst_i(rst_i), .clkstrb_i(clkstrb_i), .run_o(run_o),
        .start_i(start_i), .rnw_i(rnw_i), .d4_i(d4_i), .blk_words_i(blk_words_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wvalid_i(wvalid_i), .wready_o(wready_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .dp_clr_o(dp_clr_o), .ctrl_rnw_o(ctrl_rnw_o), .ctrl_d4_o(ctrl_d4_o),
        .ctrl_rot_reg_o(ctrl_rot_reg_o), .ctrl_omux_o(ctrl_omux_o),
        .ctrl_output_crc_o(ctrl_output_crc_o), .shift_s_o(shift_s_o), .load_p_o(load_p_o),
        .sd_dat_oe_o(sd_dat_oe_o), .sd_dat0_i(sd_dat0_i), .crc_nonzero_i(crc_nonzero_i)
    );

    always #5 clk = ~clk;

    // SD clock strobe every other cycle, suppressed whenever run_o is low
    always @(posedge clk) strb_raw <= ~strb_raw;
    assign clkstrb_i = strb_raw & run_o;

    // Card model
    bit         card_arm = 1'b0;
    bit         card_rd = 1'b0;
    bit         card_end = 1'b1;
    int         card_lead = 0;
    int         card_endpos = 0;
    logic [9:0] card_wvec = '1;
    int         card_pos;

    always_comb begin
        sd_dat0_i = 1'b1;
        if (card_arm) begin
            if (card_rd) begin
                if (card_pos < card_lead)        sd_dat0_i = 1'b1;
                else if (card_pos == card_lead)  sd_dat0_i = 1'b0;
                else if (card_pos < card_endpos) sd_dat0_i = card_pos[0];
                else if (card_pos == card_endpos) sd_dat0_i = card_end;
            end else if (card_pos < 10) begin
                sd_dat0_i = card_wvec[card_pos[3:0]];
            end
        end
    end

    // Event monitors
    bit         mon_clr = 1'b0;
    logic [3:0] exp_oe = 4'h0;
    int oe_strb, shift_strb, rot_strb, load_cnt, rd_cnt, done_cnt, dpclr_cnt, oe_bad;

    always @(posedge clk) begin
        if (mon_clr) begin
            oe_strb <= 0; shift_strb <= 0; rot_strb <= 0; load_cnt <= 0;
            rd_cnt <= 0; done_cnt <= 0; dpclr_cnt <= 0; oe_bad <= 0;
        end else begin
            if (clkstrb_i && sd_dat_oe_o != 4'h0) oe_strb <= oe_strb + 1;
            if (clkstrb_i && shift_s_o) shift_strb <= shift_strb + 1;
            if (clkstrb_i && shift_s_o && ctrl_rot_reg_o) rot_strb <= rot_strb + 1;
            if (load_p_o) load_cnt <= load_cnt + 1;
            if (rvalid_o && rready_i) rd_cnt <= rd_cnt + 1;
            if (done_o) done_cnt <= done_cnt + 1;
            if (dp_clr_o) dpclr_cnt <= dpclr_cnt + 1;
            if (sd_dat_oe_o != 4'h0 && sd_dat_oe_o != exp_oe) oe_bad <= oe_bad + 1;
        end
        if (!card_arm) card_pos <= 0;
        else if (clkstrb_i) card_pos <= card_pos + 1;
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (done_o) got = 1'b1;
        end
    endtask

    task automatic wait_oe(input bit want, output bit got);
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if ((sd_dat_oe_o != 4'h0) == want) got = 1'b1;
        end
    endtask

    typedef struct {
        bit         rnw;
        bit         d4;
        int         blk;
        logic [9:0] wcard;
        int         lead;
        bit         end_bit;
        bit         crc_nz;
        int         exp_err;
        int         exp_pos;
        int         exp_words;
        int         exp_oe;
        int         exp_shift;
        int         exp_rot;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        bit got;
        string p;
        p = $sformatf("v%0d_", idx);
        mon_clr  = 1'b1;
        card_arm = 1'b0;
        @(negedge clk);
        mon_clr       = 1'b0;
        rnw_i         = v.rnw;
        d4_i          = v.d4;
        blk_words_i   = 7'(v.blk);
        crc_nonzero_i = v.crc_nz;
        wvalid_i      = !v.rnw;
        rready_i      = 1'b1;
        card_rd       = v.rnw;
        card_lead     = v.lead;
        card_end      = v.end_bit;
        card_wvec     = v.wcard;
        card_endpos   = v.lead + 1 + (v.blk + 1) * (v.d4 ? 8 : 32) + 16;
        exp_oe        = v.d4 ? 4'hF : 4'h1;
        start_i       = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk({p, "busy"}, busy_o, 1);
        chk({p, "err_clr"}, err_o, 0);
        if (v.rnw) begin
            card_arm = 1'b1;
        end else begin
            wait_oe(1'b1, got);
            chk({p, "oe_rise"}, got, 1);
            wait_oe(1'b0, got);
            chk({p, "oe_fall"}, got, 1);
            card_arm = 1'b1;
        end
        wait_done(got);
        chk({p, "done_seen"}, got, 1);
        chk({p, "err"}, err_o, v.exp_err);
        chk({p, "card_strobes"}, card_pos, v.exp_pos);
        repeat (3) @(negedge clk);
        chk({p, "err_hold"}, err_o, v.exp_err);
        chk({p, "idle"}, busy_o, 0);
        chk({p, "words"}, v.rnw ? rd_cnt : load_cnt, v.exp_words);
        chk({p, "oe_strobes"}, oe_strb, v.exp_oe);
        chk({p, "shift_strobes"}, shift_strb, v.exp_shift);
        chk({p, "rot_strobes"}, rot_strb, v.exp_rot);
        chk({p, "oe_value"}, oe_bad, 0);
        chk({p, "done_pulses"}, done_cnt, 1);
        chk({p, "dp_clr"}, dpclr_cnt, 1);
        wvalid_i = 1'b0;
    endtask

    localparam logic [9:0] WC_OK   = 10'b1000101001;
    localparam logic [9:0] WC_REJ  = 10'b1000110101;
    localparam logic [9:0] WC_NONE = 10'b1111111111;

    initial begin
        vec_t vecs[9];
        bit   got;
        int   hold_pos;
        int   stall_bad;

        vecs[0] = '{1'b0, 1'b1, 0, WC_OK,   0,    1'b1, 1'b0, 0, 10, 1, 26, 24, 0};
        vecs[1] = '{1'b0, 1'b1, 0, WC_REJ,  0,    1'b1, 1'b0, 4, 10, 1, 26, 24, 0};
        vecs[2] = '{1'b0, 1'b0, 1, WC_OK,   0,    1'b1, 1'b0, 0, 10, 2, 82, 80, 64};
        vecs[3] = '{1'b0, 1'b1, 0, WC_NONE, 0,    1'b1, 1'b0, 1, 63, 1, 26, 24, 0};
        vecs[4] = '{1'b1, 1'b0, 1, WC_NONE, 5,    1'b1, 1'b0, 0, 87, 2, 0,  80, 64};
        vecs[5] = '{1'b1, 1'b0, 1, WC_NONE, 5,    1'b1, 1'b1, 2, 87, 2, 0,  80, 64};
        vecs[6] = '{1'b1, 1'b0, 1, WC_NONE, 5,    1'b0, 1'b0, 3, 87, 2, 0,  80, 64};
        vecs[7] = '{1'b1, 1'b1, 3, WC_NONE, 2,    1'b0, 1'b1, 3, 52, 4, 0,  48, 0};
        vecs[8] = '{1'b1, 1'b0, 0, WC_NONE, 1000, 1'b1, 1'b0, 1, 63, 0, 0,  0,  0};

        // Reset state
        rst_i   = 1'b1;
        mon_clr = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_run", run_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_omux", ctrl_omux_o, 1);
        chk("rst_oe", sd_dat_oe_o, 0);
        chk("rst_ctrl", {done_o, wready_o, rvalid_o, dp_clr_o, ctrl_rnw_o, ctrl_d4_o,
                         ctrl_rot_reg_o, ctrl_output_crc_o, shift_s_o, load_p_o}, 0);
        rst_i   = 1'b0;
        mon_clr = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], i);
        end

        // Read d1, host holds rready low for 20 cycles after the first word
        mon_clr = 1'b1; card_arm = 1'b0;
        @(negedge clk);
        mon_clr = 1'b0;
        rnw_i = 1'b1; d4_i = 1'b0; blk_words_i = 7'd1; crc_nonzero_i = 1'b0;
        rready_i = 1'b0; card_rd = 1'b1; card_lead = 5; card_end = 1'b1;
        card_endpos = 5 + 1 + 64 + 16;
        start_i = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        card_arm = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (rvalid_o) got = 1'b1;
        end
        chk("stall_rvalid_seen", got, 1);
        chk("stall_rvalid_time", card_pos, 38);
        hold_pos  = card_pos;
        stall_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (run_o || card_pos != hold_pos || !rvalid_o) stall_bad++;
        end
        chk("stall_clock_held", stall_bad, 0);
        rready_i = 1'b1;
        wait_done(got);
        chk("stall_done_seen", got, 1);
        chk("stall_err", err_o, 0);
        chk("stall_strobes", card_pos, 87);
        @(negedge clk);
        chk("stall_words", rd_cnt, 2);

        // Reset in the middle of W_DATA
        mon_clr = 1'b1; card_arm = 1'b0;
        @(negedge clk);
        mon_clr = 1'b0;
        rnw_i = 1'b0; d4_i = 1'b1; blk_words_i = 7'd0; wvalid_i = 1'b1; exp_oe = 4'hF;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (shift_s_o && ctrl_omux_o == 2'd2) got = 1'b1;
        end
        chk("rst_mid_reached_data", got, 1);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i    = 1'b0;
        wvalid_i = 1'b0;
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_oe", sd_dat_oe_o, 0);
        chk("rst_mid_run", run_o, 1);
        chk("rst_mid_omux", ctrl_omux_o, 1);
        chk("rst_mid_shift", shift_s_o, 0);
        repeat (40) @(negedge clk);
        chk("rst_mid_no_done", done_cnt, 0);
        chk("rst_mid_still_idle", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/neosd_dat_ctrl.md
# neosd_dat_ctrl

Sequencer for the SD DAT-line datapath (`neosd_dat_block`). It runs one single-block data transfer in 1-bit or 4-bit mode:
- write: start bit, data, CRC16, end bit, CRC status token, busy wait;
- read: start-bit search, data, CRC check, end bit.

It generates the datapath control lines, exchanges 32-bit words with the host through valid/ready handshakes, and stalls the SD clock when the host is slow.

## Interface
- `WCNT_W`, 7: width of word-count field (max block 2^WCNT_W words)
- `TOUT_W`, 16: width of start-bit / status timeout counter (counts SD clocks)
- `clk_i` in 1: system clock
- `rst_i` in 1: reset, synchronous, active-high
- `clkstrb_i` in 1: SD bit-clock strobe, one `clk_i` cycle wide
- `run_o` out 1: clock-run request; clock generator suppresses `clkstrb_i` in any cycle where `run_o`=0
- `start_i` in 1: start transfer (sampled in IDLE only)
- `rnw_i` in 1: 1=read, 0=write (latched at start)
- `d4_i` in 1: 4-bit mode (latched at start)
- `blk_words_i` in WCNT_W: words per block minus one (latched at start)
- `busy_o` out 1: not IDLE
- `done_o` out 1: one-cycle pulse at end of transfer
- `err_o` out 3: result code, valid with `done_o`; held until next start:
  - 0 ok
  - 1 start/status timeout
  - 2 CRC error
  - 3 end-bit error
  - 4 write rejected
  - 5 busy timeout
- `wvalid_i` in 1 / `wready_o` out 1: write word handshake; word on datapath `data_p_i`
- `rvalid_o` out 1 / `rready_i` in 1: read word handshake; word on datapath `data_p_o`
- `dp_clr_o` out 1: one-cycle datapath clear pulse; top level combines it into the datapath reset
- `ctrl_rnw_o`, `ctrl_d4_o`, `ctrl_rot_reg_o`, `ctrl_omux_o`[1:0], `ctrl_output_crc_o`, `shift_s_o`, `load_p_o` out: datapath controls
- `sd_dat_oe_o` out 4: per-line output enable
- `sd_dat0_i` in 1: DAT0 level
- `crc_nonzero_i` in 1: datapath CRC remainder flag

## Operation
- Reset values:
  - state IDLE
  - `run_o`=1
  - `err_o`=0
  - all other outputs 0
  - `ctrl_omux_o`=1
- IDLE:
  - On `start_i`, latch `rnw_i`, `d4_i`, `blk_words_i`.
  - Pulse `dp_clr_o`; clear counters.
  - Go to W_FILL (write) or R_WAIT (read).
  - `start_i` outside IDLE is ignored.
- `ctrl_rnw_o` and `ctrl_d4_o` drive the latched values.
- `ctrl_rot_reg_o` = !d4 during data states only.
- Bits per word: 8 (d4) or 32 (d1).
- Write sequence:
  - W_FILL: `wready_o`=1, `run_o`=0. On `wvalid_i`, pulse `load_p_o` and go to W_START.
  - W_START: OE asserted (0x1 in d1, 0xF in d4), omux=0. Holds for one SD clock.
  - W_DATA: omux=2, `shift_s_o`=1. On the last bit strobe of a word:
    - if more words remain, go to W_NEXT;
    - otherwise go to W_CRC.
  - W_NEXT: `wready_o`=1, `run_o`=0, `shift_s_o`=0. On `wvalid_i`, pulse `load_p_o` and return to W_DATA.
  - W_CRC: omux=3, `ctrl_output_crc_o`=1, `shift_s_o`=1, 16 strobes.
  - W_END: omux=1, one strobe.
  - W_SWAIT:
    - OE=0.
    - Wait for `sd_dat0_i`=0 on a strobe.
    - Timeout after 2^TOUT_W−1 strobes → err 1.
  - W_STAT: sample 3 bits on DAT0. Status ≠ 3'b010 → err 4 (busy wait still runs).
  - W_SEND: skip one strobe.
  - W_BUSY: wait while `sd_dat0_i`=0 on strobes.
  - DONE.
- Read sequence:
  - R_WAIT: OE=0. On the first strobe with `sd_dat0_i`=0, go to R_DATA. Timeout → err 1.
  - R_DATA: `shift_s_o`=1. On the last bit strobe of each word, set `rvalid_o`.
  - `run_o` = !(`rvalid_o` & !`rready_i`) (combinational).
  - `rvalid_o` clears on handshake.
  - After the last word, go to R_CRC.
  - R_CRC: `shift_s_o`=1, `ctrl_rot_reg_o`=0, 16 strobes.
  - R_END:
    - Sample DAT0: 0 → err 3.
    - Else if `crc_nonzero_i` → err 2.
    - Go to DONE once `rvalid_o` is clear.
- DONE: pulse `done_o`, return to IDLE.
- Error priority when several apply: 1 > 3 > 2 > 4 > 5.
- Counters:
  - bit counter, 5 bits, wraps per word;
  - word counter, WCNT_W bits, compared to the latched value;
  - CRC counter, 4 bits;
  - timeout counter, TOUT_W bits, saturating.

## Timing
- All SD-side transitions happen on `clk_i` edges where `clkstrb_i`=1.
- Handshake states (W_FILL, W_NEXT, `rvalid_o` wait) advance on any `clk_i`.
- Control outputs are registered. A value set on strobe n is applied to the datapath at strobe n+1, one SD bit period.
- `load_p_o` is asserted in the same cycle as the `wvalid_i` & `wready_o` handshake.
- `rvalid_o` rises one `clk_i` cycle after the final-bit strobe.
- Write frame length = 1 + 8·(N+1)·(d4?1:4) + 16 + 1 SD clocks before release.
- `rst_i` mid-transfer: return to IDLE next cycle, all outputs take reset values, no `done_o`.

## Configuration
- `NEOSD_DAT_BUSY_TOUT_EN`:
  - Defined: W_BUSY reuses the timeout counter; expiry → err 5, DONE.
  - Undefined: W_BUSY waits indefinitely; err 5 is never produced.

## Test plan
- Write, d4, `blk_words_i`=0, word 0xA5A5_5A5A, card returns status 010 then 3 busy clocks → DAT lines 0, 8 data nibbles, 16 CRC, 1; `done_o` with err 0 after busy.
- Read, d1, `blk_words_i`=1, card sends start bit after 5 clocks, valid CRC → two `rvalid_o` words match sent data, err 0.
- Read, `rready_i` held low 20 cycles after first word → `run_o`=0 and no `clkstrb_i` for 20 cycles, no data loss.
- Read with one flipped CRC bit → err 2. Repeat with end bit 0 → err 3.
- No start bit for 2^TOUT_W strobes → err 1.
- Write status 101 → err 4.
- `rst_i` asserted mid W_DATA → IDLE next cycle, OE=0, `busy_o`=0, no `done_o`.
